// File: rtl/tlc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tlc_pkg : shared state/light encodings and default phase times   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package tlc_pkg;

  typedef enum logic [2:0] {
    MG  = 3'd0,
    MY  = 3'd1,
    AR1 = 3'd2,
    SG  = 3'd3,
    SY  = 3'd4,
    AR2 = 3'd5
  } state_e;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam int TW_DEF        = 6;
  localparam int T_MG_MIN_DEF  = 10;
  localparam int T_Y_DEF       = 3;
  localparam int T_AR_DEF      = 1;
  localparam int T_SG_DEF      = 8;
  localparam int T_PED_CLR_DEF = 3;

  // Timer load value for a duration; a zero duration behaves as one second.
  function automatic int dur_m1(input int d);
    return (d <= 0) ? 0 : d - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tlc_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tlc_timer : loadable down-counter with optional hold at zero     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tlc_timer #(
  parameter int             TW      = 6,
  parameter logic [TW-1:0]  RST_VAL = '0
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          hold_at_zero,
  output logic [TW-1:0] tmr,
  output logic          zero
);

  logic [TW-1:0] tmr_q, tmr_d;

  always_comb begin
    tmr_d = tmr_q;
    if (load) begin
      tmr_d = load_val;
    end else if (!(hold_at_zero && (tmr_q == '0))) begin
      tmr_d = tmr_q - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmr_q <= RST_VAL;
    end else begin
      tmr_q <= tmr_d;
    end
  end

  assign tmr  = tmr_q;
  assign zero = (tmr_q == '0);

endmodule
`default_nettype wire

// File: rtl/tlc_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tlc_fsm : main/side traffic light controller with ped crossing   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tlc_fsm
  import tlc_pkg::*;
#(
  parameter int TW        = TW_DEF,
  parameter int T_MG_MIN  = T_MG_MIN_DEF,
  parameter int T_Y       = T_Y_DEF,
  parameter int T_AR      = T_AR_DEF,
  parameter int T_SG      = T_SG_DEF,
  parameter int T_PED_CLR = T_PED_CLR_DEF
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          car_side,
  input  logic          ped_req,
  output logic [2:0]    main_light,
  output logic [2:0]    side_light,
  output logic          walk,
  output logic [TW-1:0] sec_left,
  output logic [2:0]    state_o
);

  localparam logic [TW-1:0] LD_MG  = TW'(dur_m1(T_MG_MIN));
  localparam logic [TW-1:0] LD_Y   = TW'(dur_m1(T_Y));
  localparam logic [TW-1:0] LD_AR  = TW'(dur_m1(T_AR));
  localparam logic [TW-1:0] LD_SG  = TW'(dur_m1(T_SG));
  localparam logic [TW-1:0] PED_CL = TW'(T_PED_CLR);

  state_e        state_q, state_d;
  logic          side_pend_q, side_pend_d;
  logic          ped_pend_q, ped_pend_d;
  logic          ped_srv_q, ped_srv_d;
  logic          tmr_load;
  logic [TW-1:0] tmr_ld_val;
  logic [TW-1:0] tmr;
  logic          tmr_zero;
  logic          demand;
  logic          enter_sg;

  assign demand   = side_pend_q | ped_pend_q;
  assign enter_sg = (state_q == AR1) && tmr_zero;

  tlc_timer #(
    .TW      (TW),
    .RST_VAL (LD_AR)
  ) u_timer (
    .clk          (clk),
    .resetn       (resetn),
    .load         (tmr_load),
    .load_val     (tmr_ld_val),
    .hold_at_zero (state_q == MG),
    .tmr          (tmr),
    .zero         (tmr_zero)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= AR2;
      side_pend_q <= 1'b0;
      ped_pend_q  <= 1'b0;
      ped_srv_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      side_pend_q <= side_pend_d;
      ped_pend_q  <= ped_pend_d;
      ped_srv_q   <= ped_srv_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_load   = 1'b0;
    tmr_ld_val = LD_AR;
    case (state_q)
      MG:  if (tmr_zero && demand) begin state_d = MY;  tmr_load = 1'b1; tmr_ld_val = LD_Y;  end
      MY:  if (tmr_zero)           begin state_d = AR1; tmr_load = 1'b1; tmr_ld_val = LD_AR; end
      AR1: if (tmr_zero)           begin state_d = SG;  tmr_load = 1'b1; tmr_ld_val = LD_SG; end
      SG:  if (tmr_zero)           begin state_d = SY;  tmr_load = 1'b1; tmr_ld_val = LD_Y;  end
      SY:  if (tmr_zero)           begin state_d = AR2; tmr_load = 1'b1; tmr_ld_val = LD_AR; end
      AR2: if (tmr_zero)           begin state_d = MG;  tmr_load = 1'b1; tmr_ld_val = LD_MG; end
      default: begin
        state_d    = AR2;
        tmr_load   = 1'b1;
        tmr_ld_val = LD_AR;
      end
    endcase
  end

  // Requests latch until the side phase starts; the clear on that edge beats a new set.
  always_comb begin
    side_pend_d = side_pend_q | (car_side && (state_q != SG));
    ped_pend_d  = ped_pend_q | ped_req;
    ped_srv_d   = ped_srv_q;
    if (enter_sg) begin
      side_pend_d = 1'b0;
      ped_pend_d  = 1'b0;
      ped_srv_d   = ped_pend_q;
    end else if ((state_q == SG) && tmr_zero) begin
      ped_srv_d   = 1'b0;
    end
  end

  always_comb begin
    main_light = RED;
    side_light = RED;
    case (state_q)
      MG:      main_light = GRN;
      MY:      main_light = YEL;
      SG:      side_light = GRN;
      SY:      side_light = YEL;
      default: begin
        main_light = RED;
        side_light = RED;
      end
    endcase
  end

  assign walk     = (state_q == SG) && ped_srv_q && (tmr >= PED_CL);
  assign sec_left = ((state_q == MG) && tmr_zero && !demand) ? '0 : tmr + TW'(1);
  assign state_o  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_tlc_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_tlc_fsm : directed self-checking bench for tlc_fsm            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_tlc_fsm;

  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;
  localparam logic [2:0] S_MG = 3'd0, S_MY = 3'd1, S_AR1 = 3'd2,
                         S_SG = 3'd3, S_SY = 3'd4, S_AR2 = 3'd5;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       car_side = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] main_light, side_light, state_o;
  logic       walk;
  logic [5:0] sec_left;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  tlc_fsm dut (
    .clk        (clk),
    .resetn     (resetn),
    .car_side   (car_side),
    .ped_req    (ped_req),
    .main_light (main_light),
    .side_light (side_light),
    .walk       (walk),
    .sec_left   (sec_left),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %0h want %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    car_side = 1'b0;
    ped_req  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    cyc    = 0;
  endtask

  // Reference phase sequence for a single side-road service requested early in MG.
  function automatic logic [2:0] exp_std(input int c);
    if (c < 1)   return S_AR2;
    if (c <= 10) return S_MG;
    if (c <= 13) return S_MY;
    if (c == 14) return S_AR1;
    if (c <= 22) return S_SG;
    if (c <= 25) return S_SY;
    if (c == 26) return S_AR2;
    return S_MG;
  endfunction

  function automatic logic [5:0] lights_of(input logic [2:0] st);
    case (st)
      S_MG:    return {G, R};
      S_MY:    return {Y, R};
      S_SG:    return {R, G};
      S_SY:    return {R, Y};
      default: return {R, R};
    endcase
  endfunction

  task automatic run_std(input bit ped_case);
    logic [2:0] es;
    for (int c = 1; c <= 28; c++) begin
      tick();
      car_side = !ped_case && (c >= 2) && (c <= 4);
      ped_req  = ped_case && (c == 5);
      es = exp_std(c);
      chk($sformatf("state p%0d", ped_case), 32'(state_o), 32'(es));
      chk($sformatf("lights p%0d", ped_case), 32'({main_light, side_light}), 32'(lights_of(es)));
      chk($sformatf("walk p%0d", ped_case), 32'(walk), 32'(ped_case && (c >= 15) && (c <= 19)));
      if (c == 10) chk("sec_left demand tmr0", 32'(sec_left), 32'd1);
      if (c == 15) chk("sec_left sg entry", 32'(sec_left), 32'd8);
    end
  endtask

  initial begin
    // Idle: rest on main green after reset recovery.
    do_reset();
    chk("rst state", 32'(state_o), 32'(S_AR2));
    chk("rst lights", 32'({main_light, side_light}), 32'({R, R}));
    chk("rst walk", 32'(walk), 32'd0);
    chk("rst sec_left", 32'(sec_left), 32'd1);
    tick();
    chk("idle mg entry", 32'(state_o), 32'(S_MG));
    chk("idle sec 10", 32'(sec_left), 32'd10);
    chk("idle lights", 32'({main_light, side_light}), 32'({G, R}));
    repeat (8) tick();
    chk("idle sec 2", 32'(sec_left), 32'd2);
    repeat (2) tick();
    chk("idle sec 0", 32'(sec_left), 32'd0);
    repeat (19) tick();
    chk("idle rests mg", 32'(state_o), 32'(S_MG));
    chk("idle sec still 0", 32'(sec_left), 32'd0);

    // Car demand, then pedestrian demand.
    do_reset();
    run_std(1'b0);
    do_reset();
    run_std(1'b1);

    // Ped request during SG is served in the following cycle.
    do_reset();
    while (cyc < 60) begin
      tick();
      car_side = (cyc >= 2) && (cyc <= 4);
      ped_req  = (cyc == 17);
      if (cyc >= 15 && cyc <= 22) chk("late ped no walk", 32'(walk), 32'd0);
      if (cyc == 27) chk("late ped mg", 32'(state_o), 32'(S_MG));
      if (cyc == 36) chk("late ped still mg", 32'(state_o), 32'(S_MG));
      if (cyc == 37) chk("late ped my", 32'(state_o), 32'(S_MY));
      if (cyc == 41) chk("late ped sg", 32'(state_o), 32'(S_SG));
      if (cyc >= 41 && cyc <= 45) chk("late ped walk on", 32'(walk), 32'd1);
      if (cyc >= 46 && cyc <= 48) chk("late ped walk clr", 32'(walk), 32'd0);
    end

    // Car sensed only on the AR1->SG edge: clear wins, no second service.
    do_reset();
    while (cyc < 45) begin
      tick();
      car_side = ((cyc >= 2) && (cyc <= 4)) || (cyc == 14);
      if (cyc == 15) chk("edge car sg", 32'(state_o), 32'(S_SG));
      if (cyc == 27) chk("edge car mg", 32'(state_o), 32'(S_MG));
      if (cyc == 37 || cyc == 44) chk("edge car stays mg", 32'(state_o), 32'(S_MG));
    end

    // Asynchronous reset mid-SG drops pending requests.
    do_reset();
    while (cyc < 20) begin
      tick();
      car_side = (cyc >= 2) && (cyc <= 4);
      ped_req  = (cyc == 5) || (cyc == 18);
    end
    chk("pre-rst side grn", 32'(side_light), 32'(G));
    #2;
    resetn = 1'b0;
    #1;
    chk("async rst lights", 32'({main_light, side_light}), 32'({R, R}));
    chk("async rst walk", 32'(walk), 32'd0);
    chk("async rst state", 32'(state_o), 32'(S_AR2));
    @(posedge clk);
    @(negedge clk);
    resetn   = 1'b1;
    car_side = 1'b0;
    ped_req  = 1'b0;
    cyc      = 0;
    tick();
    chk("post-rst mg", 32'(state_o), 32'(S_MG));
    repeat (14) tick();
    chk("post-rst pend lost", 32'(state_o), 32'(S_MG));
    chk("post-rst sec 0", 32'(sec_left), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety invariant sampled away from the active edge.
  always @(negedge clk) begin
    if (main_light != R && side_light != R) begin
      chk("both non-red", 32'({main_light, side_light}), 32'({R, R}));
    end
  end

endmodule
`default_nettype wire
